mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameters: AW, default 5, address width; DW, default 8, data width; MEM_LAT, default 1 (legal 1..4), memory access cycles.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports c_req/l_req  input  1  CPU / loader access request, held until matching done.
REQ-005 SHALL have ports c_we/l_we  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports c_addr/l_addr  input  AW  access address.
REQ-007 SHALL have ports c_wdata/l_wdata  input  DW  write data.
REQ-008 SHALL have ports c_done/l_done  output  1  one-cycle completion pulse.
REQ-009 SHALL have port rdata  output  DW  registered read data, valid while a done is high.
REQ-010 SHALL have ports mem_addr (AW), mem_wdata (DW), mem_read (1), mem_write (1)  output  memory drive.
REQ-011 SHALL have port mem_rdata  input  DW  memory read data.
REQ-012 SHALL have ports busy  output  1  state != IDLE; owner  output  1  0 = CPU, 1 = loader, current/last grant.

Function
REQ-013 SHALL implement FSM IDLE -> BUSY -> RESP -> IDLE; no other states reachable.
REQ-014 IDLE: if any req high, SHALL pick winner, latch its we/addr/wdata, set owner, load wait counter with MEM_LAT-1, go BUSY; else stay IDLE.
REQ-015 Arbitration, default: CPU wins when both requests are high.
REQ-016 BUSY: SHALL drive mem_addr/mem_wdata from latched values and assert mem_read (read) or mem_write (write) for exactly MEM_LAT consecutive cycles; counter decrements each cycle, exit to RESP when counter is 0.
REQ-017 On the edge leaving the last BUSY cycle of a read, SHALL register mem_rdata into rdata; writes SHALL leave rdata unchanged.
REQ-018 RESP: SHALL assert done of the owner only, for exactly one cycle; mem_read/mem_write low; go IDLE.
REQ-019 Latency: request sampled at IDLE edge E -> done high during cycle MEM_LAT+1 after E (MEM_LAT=1: second cycle).
REQ-020 Requester SHALL drop req on the edge ending its done cycle; arbiter SHALL ignore req in BUSY and RESP; changes to addr/wdata/we after grant SHALL have no effect.
REQ-021 Back-to-back: a still-pending loser SHALL be granted in the IDLE cycle immediately after RESP (no extra idle cycle).
REQ-022 mem_read and mem_write SHALL never be high simultaneously; c_done and l_done SHALL never be high simultaneously.
REQ-023 Outside BUSY, mem_addr/mem_wdata SHALL hold last latched values.

Reset
REQ-024 rst high at a rising edge SHALL force: state IDLE, busy 0, owner 0, c_done 0, l_done 0, rdata 0, mem_read 0, mem_write 0, mem_addr 0, mem_wdata 0, counter 0, round-robin pointer favouring CPU.
REQ-025 Reset mid-BUSY/RESP SHALL abort the access with no done pulse; requests still high after reset release SHALL be re-arbitrated from IDLE.

Configuration
REQ-026 Macro ARB_ROUND_ROBIN_EN: when defined, on simultaneous requests the requester not granted last SHALL win (pointer updates on each grant, CPU favoured after reset); when undefined, fixed CPU priority per REQ-015 and no pointer register exists.

Verification
REQ-027 Single CPU read, MEM_LAT=1, mem_rdata=8'hA5 at addr 5'h03 -> mem_read high 1 cycle with mem_addr 5'h03, c_done and rdata=8'hA5 in the 2nd cycle after sampling.
REQ-028 Loader write addr 5'h1F data 8'h3C, MEM_LAT=3 -> mem_write high exactly 3 cycles, l_done 1 cycle later, rdata unchanged.
REQ-029 c_req and l_req both held, macro undefined -> CPU granted repeatedly, loader never done while CPU keeps requesting; macro defined -> grants alternate CPU, loader, CPU.
REQ-030 rst asserted in 2nd BUSY cycle (MEM_LAT=4) -> next cycle all outputs at reset values, no done; held req serviced after release.
REQ-031 CPU read then pending loader read -> l access enters BUSY the cycle after c_done's IDLE cycle, total 6 cycles for both at MEM_LAT=1, done never overlap.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if -- bus bundle for mem_arbiter.
//   Requester side : c_*/l_* request, we, addr, wdata in; c_done/l_done out.
//   Memory side    : mem_addr, mem_wdata, mem_read, mem_write out; mem_rdata in.
//   Status         : rdata, busy, owner out.
// Modports: slave = arbiter view, master = requester/memory/bench view.
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic          c_req, c_we, c_done;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          l_req, l_we, l_done;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_read, mem_write;
  logic          busy, owner;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    output c_done, l_done, rdata, mem_addr, mem_wdata, mem_read, mem_write, busy, owner
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, l_req, l_we, l_addr, l_wdata, mem_rdata,
    input  c_done, l_done, rdata, mem_addr, mem_wdata, mem_read, mem_write, busy, owner
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter -- two-requester (CPU, loader) single-port memory arbiter.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : mem_arbiter_if.slave (requests, done pulses, memory drive, status)
// Parameters: AW address width, DW data width, MEM_LAT memory cycles (1..4).
// Optional macro ARB_ROUND_ROBIN_EN: on simultaneous requests the requester
// not granted last wins; otherwise the CPU always has priority.
// Flow: IDLE -> BUSY (MEM_LAT cycles) -> RESP (one done cycle) -> IDLE.
module mem_arbiter #(
  parameter int AW      = 5,
  parameter int DW      = 8,
  parameter int MEM_LAT = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);

  logic [1:0]    state;
  logic [1:0]    cnt;
  logic          we_q;
  logic          owner_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic          win_l;   // loader wins this arbitration

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_l;             // 1: loader favoured on a tie

  always_comb win_l = bus.l_req && (!bus.c_req || rr_l);

  always_ff @(posedge clk) begin
    if (rst)
      rr_l <= 1'b0;
    else if (state == IDLE && (bus.c_req || bus.l_req))
      rr_l <= !win_l;     // favour whoever just lost
  end
`else
  always_comb win_l = bus.l_req && !bus.c_req;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      we_q    <= 1'b0;
      owner_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.c_req || bus.l_req) begin
            owner_q <= win_l;
            we_q    <= win_l ? bus.l_we    : bus.c_we;
            addr_q  <= win_l ? bus.l_addr  : bus.c_addr;
            wdata_q <= win_l ? bus.l_wdata : bus.c_wdata;
            cnt     <= LAT_M1;
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == 2'd0) begin
            state <= RESP;
            if (!we_q) rdata_q <= bus.mem_rdata;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address/data come straight from the latch, so they hold outside BUSY.
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_read  = (state == BUSY) && !we_q;
  assign bus.mem_write = (state == BUSY) &&  we_q;
  assign bus.c_done    = (state == RESP) && !owner_q;
  assign bus.l_done    = (state == RESP) &&  owner_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = (state != IDLE);
  assign bus.owner     = owner_q;
endmodule
